// File: rtl/alu_nibble_sequencer.sv
// Runs WIDTH-bit operations on an external combinational 4-bit ALU slice,
// one nibble per clock, chaining slice carries and assembling the result.
//
// state | meaning
// IDLE  | waiting for a request; in_ready high while rst_n is high
// RUN   | one nibble per cycle through the slice, NIB cycles
// DONE  | result and flags held until the consumer takes them
module alu_nibble_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [2:0]       op_f,
    input  logic             op_com,
    input  logic             op_cin,
    output logic [3:0]       alu_a,
    output logic [3:0]       alu_b,
    output logic [2:0]       alu_f,
    output logic             alu_com,
    output logic             alu_ci_right,
    output logic             alu_ci_left,
    input  logic [3:0]       alu_d,
    input  logic             alu_co_left,
    input  logic             alu_co_right,
    input  logic             alu_equ,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] result,
    output logic             res_carry,
    output logic             res_zero,
    output logic             res_equal
);

    localparam int NIB = WIDTH / 4;
    localparam int SW  = $clog2(NIB);

    localparam logic [2:0] F_ADD = 3'd0;
    localparam logic [2:0] F_SHR = 3'd6;
    localparam logic [2:0] F_SHL = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [SW-1:0]    step_q;
    logic [WIDTH-1:0] a_q, b_q, result_q, result_upd;
    logic [2:0]       f_q;
    logic             com_q, cin_q, carry_q, equal_q, carry_res_q, zero_q;

    logic [SW-1:0]    nib_idx;
    logic [SW+1:0]    bit_base;
    logic             is_shr, is_add_shl, first_step, last_step, chain_ci;

    always_comb begin
        is_shr     = (f_q == F_SHR);
        is_add_shl = (f_q == F_ADD) || (f_q == F_SHL);
        first_step = (step_q == '0);
        last_step  = (step_q == SW'(NIB - 1));
        // SHR walks MSB-first so the right-going carry reaches lower nibbles
        nib_idx    = is_shr ? (SW'(NIB - 1) - step_q) : step_q;
        bit_base   = {nib_idx, 2'b00};
        chain_ci   = first_step ? cin_q : carry_q;
        result_upd = result_q;
        result_upd[bit_base +: 4] = alu_d;
    end

    always_comb begin
        state_d      = state_q;
        in_ready     = 1'b0;
        res_valid    = 1'b0;
        alu_a        = 4'd0;
        alu_b        = 4'd0;
        alu_f        = 3'd0;
        alu_com      = 1'b0;
        alu_ci_right = 1'b0;
        alu_ci_left  = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = rst_n;
                if (in_valid && rst_n) state_d = RUN;
            end
            RUN: begin
                alu_a   = a_q[bit_base +: 4];
                alu_b   = b_q[bit_base +: 4];
                alu_f   = f_q;
                alu_com = com_q;
                if (is_add_shl) alu_ci_right = chain_ci;
                if (is_shr)     alu_ci_left  = chain_ci;
                if (last_step)  state_d = DONE;
            end
            DONE: begin
                res_valid = 1'b1;
                if (res_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            step_q      <= '0;
            a_q         <= '0;
            b_q         <= '0;
            f_q         <= 3'd0;
            com_q       <= 1'b0;
            cin_q       <= 1'b0;
            carry_q     <= 1'b0;
            result_q    <= '0;
            equal_q     <= 1'b0;
            carry_res_q <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q         <= op_a;
                        b_q         <= op_b;
                        f_q         <= op_f;
                        com_q       <= op_com;
                        cin_q       <= op_cin;
                        result_q    <= '0;
                        equal_q     <= 1'b1;
                        step_q      <= '0;
                        carry_q     <= 1'b0;
                        carry_res_q <= 1'b0;
                        zero_q      <= 1'b0;
                    end
                end
                RUN: begin
                    result_q <= result_upd;
                    equal_q  <= equal_q & alu_equ;
                    carry_q  <= is_shr ? alu_co_right : alu_co_left;
                    step_q   <= step_q + SW'(1);
                    if (last_step) begin
                        step_q      <= '0;
                        carry_res_q <= is_add_shl ? alu_co_left :
                                       (is_shr ? alu_co_right : 1'b0);
                        zero_q      <= (result_upd == '0);
                    end
                end
                default: ;
            endcase
        end
    end

    assign result    = result_q;
    assign res_carry = carry_res_q;
    assign res_zero  = zero_q;
    assign res_equal = equal_q;

endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// Bench for alu_nibble_sequencer: behavioural slice, whole-word reference
// model, per-cycle compare process, directed and randomized stimulus.
module tb_alu_nibble_sequencer;

    localparam int WIDTH = 16;
    localparam int NIB   = WIDTH / 4;

    logic             clk, rst_n, in_valid, in_ready, op_com, op_cin;
    logic [WIDTH-1:0] op_a, op_b, result;
    logic [2:0]       op_f, alu_f;
    logic [3:0]       alu_a, alu_b, alu_d;
    logic             alu_com, alu_ci_right, alu_ci_left;
    logic             alu_co_left, alu_co_right, alu_equ;
    logic             res_valid, res_ready, res_carry, res_zero, res_equal;

    alu_nibble_sequencer #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op_a(op_a), .op_b(op_b), .op_f(op_f), .op_com(op_com), .op_cin(op_cin),
        .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f), .alu_com(alu_com),
        .alu_ci_right(alu_ci_right), .alu_ci_left(alu_ci_left),
        .alu_d(alu_d), .alu_co_left(alu_co_left), .alu_co_right(alu_co_right),
        .alu_equ(alu_equ), .res_valid(res_valid), .res_ready(res_ready),
        .result(result), .res_carry(res_carry), .res_zero(res_zero),
        .res_equal(res_equal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 4-bit combinational slice
    always_comb begin
        logic [4:0] s;
        alu_d        = 4'd0;
        alu_co_left  = 1'b0;
        alu_co_right = 1'b0;
        s            = 5'd0;
        case (alu_f)
            3'd0: begin
                s = {1'b0, alu_a} + {1'b0, alu_b} + {4'd0, alu_ci_right};
                alu_d = s[3:0];
                alu_co_left = s[4];
            end
            3'd1: alu_d = alu_a & alu_b;
            3'd2: alu_d = alu_a | alu_b;
            3'd3: alu_d = alu_a ^ alu_b;
            3'd4: alu_d = alu_a;
            3'd5: alu_d = alu_b;
            3'd6: begin
                alu_d = {alu_ci_left, alu_a[3:1]};
                alu_co_right = alu_a[0];
            end
            default: begin
                alu_d = {alu_a[2:0], alu_ci_right};
                alu_co_left = alu_a[3];
            end
        endcase
        if (alu_com) alu_d = ~alu_d;
        alu_equ = (alu_a == alu_b);
    end

    int     n_checks = 0;
    int     n_fail   = 0;
    longint cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, got, exp, cyc);
        end
    endtask

    task automatic model(input logic [WIDTH-1:0] a, b, input logic [2:0] f,
                         input logic com, cin, output logic [WIDTH-1:0] r,
                         output logic c, z, e);
        logic [WIDTH:0] t;
        c = 1'b0;
        t = '0;
        case (f)
            3'd0: begin t = {1'b0, a} + {1'b0, b} + (WIDTH+1)'(cin); r = t[WIDTH-1:0]; c = t[WIDTH]; end
            3'd1: r = a & b;
            3'd2: r = a | b;
            3'd3: r = a ^ b;
            3'd4: r = a;
            3'd5: r = b;
            3'd6: begin r = {cin, a[WIDTH-1:1]}; c = a[0]; end
            default: begin r = {a[WIDTH-2:0], cin}; c = a[WIDTH-1]; end
        endcase
        if (com) r = ~r;
        z = (r == '0);
        e = (a == b);
    endtask

    task automatic exp_step(input logic [WIDTH-1:0] a, b, input logic [2:0] f,
                            input logic cin, input int k, output logic [3:0] ea, eb,
                            output logic eci_r, eci_l);
        int     idx;
        longint m, s;
        idx   = (f == 3'd6) ? (NIB - 1 - k) : k;
        ea    = a[idx*4 +: 4];
        eb    = b[idx*4 +: 4];
        eci_r = 1'b0;
        eci_l = 1'b0;
        if (f == 3'd0) begin
            if (k == 0) eci_r = cin;
            else begin
                m = (64'd1 << (idx*4)) - 1;
                s = (longint'(a) & m) + (longint'(b) & m) + longint'(cin);
                eci_r = s[idx*4];
            end
        end else if (f == 3'd7) begin
            if (k == 0) eci_r = cin;
            else eci_r = a[idx*4-1];
        end else if (f == 3'd6) begin
            if (k == 0) eci_l = cin;
            else eci_l = a[idx*4+4];
        end
    endtask

    bit               known = 0, busy = 0;
    longint           acc_edge = 0;
    logic [WIDTH-1:0] ma, mb, er;
    logic [2:0]       mf;
    logic             mcom, mcin, ec, ez, ee;
    logic [3:0]       seq [NIB];

    always @(negedge clk) begin
        longint     k;
        logic [3:0] ea, eb;
        logic       ecr, ecl;
        if (known) begin
            if (!busy) begin
                chk("idle_in_ready", in_ready, rst_n);
                chk("idle_res_valid", res_valid, 0);
                chk("idle_alu", {alu_a, alu_b, alu_f, alu_com, alu_ci_right, alu_ci_left}, 0);
            end else begin
                k = cyc - acc_edge;
                chk("busy_in_ready", in_ready, 0);
                if (k < NIB) begin
                    exp_step(ma, mb, mf, mcin, int'(k), ea, eb, ecr, ecl);
                    seq[k] = alu_a;
                    chk("run_res_valid", res_valid, 0);
                    chk("run_alu_a", alu_a, ea);
                    chk("run_alu_b", alu_b, eb);
                    chk("run_alu_f_com", {alu_f, alu_com}, {mf, mcom});
                    chk("run_ci_right", alu_ci_right, ecr);
                    chk("run_ci_left", alu_ci_left, ecl);
                end else begin
                    chk("done_res_valid", res_valid, 1);
                    chk("done_result", result, er);
                    chk("done_flags", {res_carry, res_zero, res_equal}, {ec, ez, ee});
                    chk("done_alu", {alu_a, alu_b, alu_f, alu_com, alu_ci_right, alu_ci_left}, 0);
                end
            end
        end
        if (!rst_n) begin
            known = 1;
            busy  = 0;
        end else if (known) begin
            if (!busy && in_valid && in_ready) begin
                busy = 1;
                acc_edge = cyc + 1;
                ma = op_a; mb = op_b; mf = op_f; mcom = op_com; mcin = op_cin;
                model(ma, mb, mf, mcom, mcin, er, ec, ez, ee);
            end else if (busy && (cyc - acc_edge) >= NIB && res_ready) begin
                busy = 0;
            end
        end
    end

    // Issues one request; leaves the caller 2 time units after the consume edge.
    task automatic do_op(input logic [WIDTH-1:0] a, b, input logic [2:0] f,
                         input logic com, cin, input int hold,
                         output logic [WIDTH-1:0] r, output logic c, z, e,
                         output int lat);
        int     t;
        bit     ok;
        longint hs_edge;
        @(posedge clk); #2;
        op_a = a; op_b = b; op_f = f; op_com = com; op_cin = cin;
        in_valid = 1; res_ready = 0;
        t = 0; ok = 0;
        while (!ok && t < 50) begin
            @(negedge clk);
            if (in_ready) ok = 1;
            t++;
        end
        if (!ok) chk("handshake_timeout", 0, 1);
        hs_edge = cyc + 1;
        @(posedge clk); #2;
        in_valid = 0; op_a = WIDTH'($urandom); op_b = WIDTH'($urandom);
        t = 0; ok = 0;
        while (!ok && t < 50) begin
            @(negedge clk);
            if (res_valid) ok = 1;
            t++;
        end
        if (!ok) chk("result_timeout", 0, 1);
        lat = int'(cyc + 1 - hs_edge);
        r = result; c = res_carry; z = res_zero; e = res_equal;
        repeat (hold) @(negedge clk);
        @(posedge clk); #2 res_ready = 1;
        @(posedge clk); #2 res_ready = 0;
    endtask

    initial begin
        logic [WIDTH-1:0] r;
        logic             c, z, e;
        int               lat;
        rst_n = 0; in_valid = 0; res_ready = 0;
        op_a = '0; op_b = '0; op_f = 3'd0; op_com = 0; op_cin = 0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1;

        do_op(16'h1234, 16'h0FCD, 3'd0, 0, 0, 0, r, c, z, e, lat);
        chk("add1_result", r, 16'h2201);
        chk("add1_flags", {c, z, e}, 3'b000);
        chk("add1_latency", lat, NIB + 1);

        do_op(16'hFFFF, 16'h0001, 3'd0, 0, 0, 0, r, c, z, e, lat);
        chk("add2_result", r, 16'h0000);
        chk("add2_carry_zero", {c, z}, 2'b11);

        do_op(16'h8001, 16'h0000, 3'd7, 0, 1, 0, r, c, z, e, lat);
        chk("shl_result", r, 16'h0003);
        chk("shl_carry", c, 1);

        do_op(16'h8001, 16'h0000, 3'd6, 0, 0, 0, r, c, z, e, lat);
        chk("shr_result", r, 16'h4000);
        chk("shr_carry", c, 1);
        chk("shr_seq", {seq[0], seq[1], seq[2], seq[3]}, 16'h8001);

        do_op(16'h00FF, 16'h0F0F, 3'd3, 1, 0, 0, r, c, z, e, lat);
        chk("xor_com_result", r, 16'hF00F);
        chk("xor_com_carry", c, 0);

        do_op(16'hABCD, 16'hABCD, 3'd4, 0, 0, 0, r, c, z, e, lat);
        chk("passa_result", r, 16'hABCD);
        chk("passa_equal", e, 1);

        do_op(16'h7777, 16'h1111, 3'd0, 0, 1, 10, r, c, z, e, lat);
        chk("bp_result", r, 16'h8889);
        chk("ready_after_release", in_ready, 1);

        // reset during step 2 of a run
        @(posedge clk); #2;
        op_a = 16'h1357; op_b = 16'h2468; op_f = 3'd0; in_valid = 1;
        begin
            int t = 0;
            while (!in_ready && t < 20) begin @(negedge clk); t++; end
            if (!in_ready) chk("rst_hs_timeout", 0, 1);
        end
        @(posedge clk); #2 in_valid = 0;
        @(posedge clk);
        @(posedge clk); #2 rst_n = 0;
        @(posedge clk); #2;
        chk("rst_res_valid", res_valid, 0);
        chk("rst_alu", {alu_a, alu_b, alu_f, alu_ci_right, alu_ci_left}, 0);
        chk("rst_in_ready_low", in_ready, 0);
        rst_n = 1;
        #1 chk("rst_in_ready_high", in_ready, 1);

        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #2;
            in_valid  = ($urandom_range(0, 2) == 0);
            res_ready = $urandom_range(0, 1);
            op_f      = 3'($urandom);
            op_com    = $urandom_range(0, 1);
            op_cin    = $urandom_range(0, 1);
            case ($urandom_range(0, 5))
                0: begin op_a = '1; op_b = WIDTH'($urandom_range(0, 2)); end
                1: begin op_a = WIDTH'($urandom); op_b = op_a; end
                default: begin op_a = WIDTH'($urandom); op_b = WIDTH'($urandom); end
            endcase
            rst_n = ($urandom_range(0, 399) != 0);
        end
        @(posedge clk); #2;
        in_valid = 0; res_ready = 1; rst_n = 1;
        repeat (NIB + 4) @(posedge clk);
        #2;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
